// File: rtl/slot_bus_ctrl_if.sv
// CPU-side bus of the Apple II/IIgs peripheral-slot controller.
// The CPU drives address/control; the controller returns read data and the stall request.
interface slot_bus_ctrl_if;
  logic        phase_ce;
  logic [7:0]  bank;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_wait;

  modport master (
    output phase_ce, bank, addr, we, cpu_dout,
    input  cpu_din, cpu_wait
  );

  modport slave (
    input  phase_ce, bank, addr, we, cpu_dout,
    output cpu_din, cpu_wait
  );
endinterface

// File: rtl/slot_bus_ctrl.sv
// Apple II/IIgs peripheral-slot bus controller: DEVSEL/IOSEL decode, C800-CFFF owner
// tracking, ready/wait stall for slow cards and the registered read byte for the CPU mux.
module slot_bus_ctrl #(
  parameter int         NUM_SLOTS  = 8,
  parameter int         WAIT_MAX   = 15,
  parameter logic [7:0] FLOAT_VAL  = 8'h80,
  parameter int         EXP_ROM_EN = 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  slot_bus_ctrl_if.slave         cpu,
  input  logic [NUM_SLOTS-1:0]   sltromsel,
  input  logic                   cxrom,
  input  logic [NUM_SLOTS*8-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]   slot_rdy,
  output logic [NUM_SLOTS-1:0]   dev_sel,
  output logic [NUM_SLOTS-1:0]   io_sel,
  output logic                   iostrobe,
  output logic [2:0]             exp_owner,
  output logic                   int_rom_sel,
  output logic                   bus_hit,
  output logic                   timeout_err,
  output logic [7:0]             slot_wr_data
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [7:0]  cnt;

  // Slot views padded to 8 entries; absent slots read as "no card", so they never decode.
  logic [7:0]  slt_pad;
  logic [7:0]  rdy_pad;
  logic [7:0]  rd_arr [8];

  logic        io_bank;
  logic        cfff_hit;
  logic [7:0]  dev_d;
  logic [7:0]  io_d;
  logic        ios_d;
  logic        irom_d;
  logic [2:0]  own_d;
  logic [2:0]  sel_d;
  logic        hit_d;

  logic [7:0]  dev_p1;
  logic [7:0]  io_p1;
  logic        ios_p1;
  logic        irom_p1;
  logic        hit_p1;
  logic [2:0]  sel_p1;
  logic        we_p1;
  logic        vld_p1;
  logic [2:0]  own_q;
  logic [7:0]  din_q;
  logic        wait_q;
  logic        terr_q;

  always_comb begin
    slt_pad = '0;
    rdy_pad = '0;
    for (int i = 0; i < 8; i++) rd_arr[i] = FLOAT_VAL;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slt_pad[i] = sltromsel[i];
      rdy_pad[i] = slot_rdy[i];
      rd_arr[i]  = slot_rd_data[i*8 +: 8];
    end
  end

  // Stage p0: combinational address decode of the current CPU cycle
  always_comb begin
    io_bank  = (cpu.bank == 8'h00) || (cpu.bank == 8'h01) ||
               (cpu.bank == 8'hE0) || (cpu.bank == 8'hE1);
    cfff_hit = (cpu.addr == 16'hCFFF);
    dev_d    = '0;
    io_d     = '0;
    ios_d    = 1'b0;
    irom_d   = 1'b0;
    own_d    = own_q;
    sel_d    = 3'd0;
    if (io_bank) begin
      if (cpu.addr[15:7] == 9'h181) begin
        if (cpu.addr[6:4] != 3'd0 && slt_pad[cpu.addr[6:4]]) begin
          dev_d[cpu.addr[6:4]] = 1'b1;
          sel_d = cpu.addr[6:4];
        end
      end else if (cpu.addr[15:11] == 5'b11000 && cpu.addr[10:8] != 3'd0) begin
        if (slt_pad[cpu.addr[10:8]] && !cxrom) begin
          io_d[cpu.addr[10:8]] = 1'b1;
          sel_d = cpu.addr[10:8];
          if (EXP_ROM_EN != 0) own_d = cpu.addr[10:8];
        end else begin
          irom_d = 1'b1;
        end
      end else if (cpu.addr[15:11] == 5'b11001) begin
        // CFFF is still served by the owner even with INTCXROM set, then releases it
        if (EXP_ROM_EN != 0 && own_q != 3'd0 && (!cxrom || cfff_hit)) begin
          ios_d = 1'b1;
          sel_d = own_q;
        end else begin
          irom_d = 1'b1;
        end
        if (cfff_hit) own_d = 3'd0;
      end
    end
    hit_d = (|dev_d) || (|io_d) || ios_d;
  end

  // Stage p1: registered strobes and the IDLE/WAIT handshake
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      dev_p1  <= '0;
      io_p1   <= '0;
      ios_p1  <= 1'b0;
      irom_p1 <= 1'b0;
      hit_p1  <= 1'b0;
      sel_p1  <= 3'd0;
      we_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      own_q   <= 3'd0;
      din_q   <= FLOAT_VAL;
      wait_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vld_p1) begin
            // One clock after the strobe: the card either answers now or stalls the CPU
            vld_p1 <= 1'b0;
            if (rdy_pad[sel_p1]) begin
              if (!we_p1) din_q <= rd_arr[sel_p1];
            end else begin
              state  <= S_WAIT;
              wait_q <= 1'b1;
              cnt    <= 8'd0;
            end
          end else if (cpu.phase_ce) begin
            dev_p1  <= dev_d;
            io_p1   <= io_d;
            ios_p1  <= ios_d;
            irom_p1 <= irom_d;
            hit_p1  <= hit_d;
            sel_p1  <= sel_d;
            we_p1   <= cpu.we;
            own_q   <= own_d;
            vld_p1  <= hit_d;
            if (!hit_d) din_q <= FLOAT_VAL;
          end
        end
        S_WAIT: begin
          if (rdy_pad[sel_p1]) begin
            if (!we_p1) din_q <= rd_arr[sel_p1];
            wait_q <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt == WAIT_MAX_C) begin
            if (!we_p1) din_q <= FLOAT_VAL;
            terr_q <= 1'b1;
            wait_q <= 1'b0;
            state  <= S_IDLE;
          end else if (cpu.phase_ce) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dev_sel      = dev_p1[NUM_SLOTS-1:0];
  assign io_sel       = io_p1[NUM_SLOTS-1:0];
  assign iostrobe     = ios_p1;
  assign int_rom_sel  = irom_p1;
  assign bus_hit      = hit_p1;
  assign exp_owner    = own_q;
  assign timeout_err  = terr_q;
  assign cpu.cpu_din  = din_q;
  assign cpu.cpu_wait = wait_q;
  assign slot_wr_data = cpu.cpu_dout;

endmodule
